// File: rtl/walk_controller_if.sv
// Walk request/indication bundle between the crossing logic and the walk controller.
// Controller samples req_* each edge; all indications are registered in the controller.
interface walk_controller_if;
    logic req_x;
    logic req_y;
    logic sx;
    logic sy;
    logic clear;
    logic pend_x;
    logic pend_y;
    logic busy;

    modport master (
        output req_x, req_y,
        input  sx, sy, clear, pend_x, pend_y, busy
    );

    modport slave (
        input  req_x, req_y,
        output sx, sy, clear, pend_x, pend_y, busy
    );
endinterface

// File: rtl/walk_controller.sv
// Round-robin X/Y walk-phase scheduler with timed walk and all-stop clearance; grant 1 edge after pend.
// No backpressure: requests are latched as sticky pend bits and served one phase at a time.
module walk_controller #(
    parameter int WALK_CYCLES  = 8,
    parameter int CLEAR_CYCLES = 2,
    parameter int CNT_W        = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    walk_controller_if.slave   wif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WALK_X,
        ST_WALK_Y,
        ST_CLEAR
    } state_e;

    typedef enum logic {
        DIR_X,
        DIR_Y
    } dir_e;

    localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_e           state_q, state_d;
    dir_e             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sx_q, sx_d;
    logic             sy_q, sy_d;
    logic             clear_q, clear_d;
    logic             pend_x_q, pend_x_d;
    logic             pend_y_q, pend_y_d;
    logic             grant_x, grant_y;

    // Ties go to the direction not served last, giving strict alternation under contention.
    always_comb begin
        grant_x = 1'b0;
        grant_y = 1'b0;
        if (state_q == ST_IDLE) begin
            grant_x = pend_x_q && (!pend_y_q || (last_q == DIR_Y));
            grant_y = pend_y_q && (!pend_x_q || (last_q == DIR_X));
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        clear_d  = clear_q;
        pend_x_d = pend_x_q | wif.req_x;
        pend_y_d = pend_y_q | wif.req_y;

        case (state_q)
            ST_IDLE: begin
                if (grant_x) begin
                    state_d  = ST_WALK_X;
                    sx_d     = 1'b1;
                    cnt_d    = WALK_LOAD;
                    last_d   = DIR_X;
                    pend_x_d = 1'b0;
                end else if (grant_y) begin
                    state_d  = ST_WALK_Y;
                    sy_d     = 1'b1;
                    cnt_d    = WALK_LOAD;
                    last_d   = DIR_Y;
                    pend_y_d = 1'b0;
                end
            end
            ST_WALK_X, ST_WALK_Y: begin
                if (cnt_q == '0) begin
                    state_d = ST_CLEAR;
                    sx_d    = 1'b0;
                    sy_d    = 1'b0;
                    clear_d = 1'b1;
                    cnt_d   = CLEAR_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    clear_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sx_d    = 1'b0;
                sy_d    = 1'b0;
                clear_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            last_q   <= DIR_Y;
            cnt_q    <= '0;
            sx_q     <= 1'b0;
            sy_q     <= 1'b0;
            clear_q  <= 1'b0;
            pend_x_q <= 1'b0;
            pend_y_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            clear_q  <= clear_d;
            pend_x_q <= pend_x_d;
            pend_y_q <= pend_y_d;
        end
    end

    assign wif.sx     = sx_q;
    assign wif.sy     = sy_q;
    assign wif.clear  = clear_q;
    assign wif.pend_x = pend_x_q;
    assign wif.pend_y = pend_y_q;
    assign wif.busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_walk_controller.sv
// Scoreboard bench for walk_controller: expected grants (direction, edge) are queued when
// requests are driven and matched when a walk output rises; phase lengths and invariants checked live.
module tb_walk_controller;

    localparam int WALK   = 8;
    localparam int CLR    = 2;
    localparam int PERIOD = WALK + CLR + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    walk_controller_if wif();

    walk_controller #(
        .WALK_CYCLES  (WALK),
        .CLEAR_CYCLES (CLR),
        .CNT_W        (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wif   (wif)
    );

    typedef struct {
        bit dir;     // 0 = X, 1 = Y
        int edge_n;  // posedge index at which the grant takes effect
    } grant_t;

    grant_t exp_q[$];
    int     n_chk = 0;
    int     n_err = 0;
    int     ecnt  = 0;

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, act, exp, ecnt);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_grant(input bit d, input int e);
        grant_t g;
        g.dir    = d;
        g.edge_n = e;
        exp_q.push_back(g);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(1);
    endtask

    // Both requests held from edge first_e to last_e, controller idle with Y served last.
    task automatic expect_window(input int first_e, input int last_e);
        int lg_x = -1000;
        int lg_y = -1000;
        bit last_dir = 1'b1;
        int t = first_e + 1;
        bit done = 1'b0;
        bit px, py;
        while (!done) begin
            px = (((first_e > lg_x + 1) ? first_e : lg_x + 1) <= ((last_e < t - 1) ? last_e : t - 1));
            py = (((first_e > lg_y + 1) ? first_e : lg_y + 1) <= ((last_e < t - 1) ? last_e : t - 1));
            if (px && (!py || last_dir)) begin
                push_grant(1'b0, t);
                lg_x = t;
                last_dir = 1'b0;
                t += PERIOD;
            end else if (py) begin
                push_grant(1'b1, t);
                lg_y = t;
                last_dir = 1'b1;
                t += PERIOD;
            end else begin
                done = 1'b1;
            end
        end
    endtask

    // Output monitor, sampled just after each active edge.
    bit     p_walk = 1'b0;
    bit     p_clr  = 1'b0;
    int     walk_len = 0;
    int     clr_len  = 0;
    bit     walk;
    grant_t g_act;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            p_walk   = 1'b0;
            p_clr    = 1'b0;
            walk_len = 0;
            clr_len  = 0;
        end else begin
            walk = wif.sx | wif.sy;
            check("sx_and_sy", int'(wif.sx & wif.sy), 0);
            check("clear_during_walk", int'(wif.clear & walk), 0);
            check("busy", int'(wif.busy), int'(walk | wif.clear));
            if (walk && !p_walk) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", 1, 0);
                end else begin
                    g_act = exp_q.pop_front();
                    check("grant_dir", int'(wif.sy), int'(g_act.dir));
                    check("grant_edge", ecnt, g_act.edge_n);
                end
                walk_len = 1;
            end else if (walk) begin
                walk_len++;
            end
            if (!walk && p_walk) begin
                check("walk_len", walk_len, WALK);
                check("clear_after_walk", int'(wif.clear), 1);
            end
            if (wif.clear && !p_clr) clr_len = 1;
            else if (wif.clear) clr_len++;
            if (!wif.clear && p_clr) check("clear_len", clr_len, CLR);
            p_walk = walk;
            p_clr  = wif.clear;
        end
    end

    int e;

    initial begin
        wif.req_x = 1'b1;
        wif.req_y = 1'b1;
        rst_n     = 1'b0;
        step(3);
        check("rst_sx", int'(wif.sx), 0);
        check("rst_sy", int'(wif.sy), 0);
        check("rst_clear", int'(wif.clear), 0);
        check("rst_pend_x", int'(wif.pend_x), 0);
        check("rst_pend_y", int'(wif.pend_y), 0);
        check("rst_busy", int'(wif.busy), 0);
        wif.req_x = 1'b0;
        wif.req_y = 1'b0;
        rst_n     = 1'b1;
        step(2);

        // Single X request
        e = ecnt + 1;
        wif.req_x = 1'b1;
        push_grant(1'b0, e + 1);
        step(1);
        wif.req_x = 1'b0;
        check("single_pend_x", int'(wif.pend_x), 1);
        step(1);
        check("single_sx_up", int'(wif.sx), 1);
        step(9);
        check("single_clear", int'(wif.clear), 1);
        step(1);
        check("single_busy_idle", int'(wif.busy), 0);
        step(3);
        check("single_q_empty", exp_q.size(), 0);

        // Tie out of reset: X then Y
        do_reset();
        e = ecnt + 1;
        wif.req_x = 1'b1;
        wif.req_y = 1'b1;
        expect_window(e, e);
        step(1);
        wif.req_x = 1'b0;
        wif.req_y = 1'b0;
        step(30);
        check("tie_q_empty", exp_q.size(), 0);

        // Both held for 100 cycles: strict alternation
        do_reset();
        e = ecnt + 1;
        wif.req_x = 1'b1;
        wif.req_y = 1'b1;
        expect_window(e, e + 99);
        step(100);
        wif.req_x = 1'b0;
        wif.req_y = 1'b0;
        step(40);
        check("rr_q_empty", exp_q.size(), 0);

        // Reset in the middle of a Y walk with X pending
        do_reset();
        e = ecnt + 1;
        wif.req_y = 1'b1;
        push_grant(1'b1, e + 1);
        step(1);
        wif.req_y = 1'b0;
        step(1);
        check("mid_sy_up", int'(wif.sy), 1);
        wif.req_x = 1'b1;
        step(1);
        wif.req_x = 1'b0;
        check("mid_pend_x", int'(wif.pend_x), 1);
        step(1);
        rst_n = 1'b0;
        step(1);
        check("mid_rst_sy", int'(wif.sy), 0);
        check("mid_rst_pend_x", int'(wif.pend_x), 0);
        check("mid_rst_busy", int'(wif.busy), 0);
        rst_n = 1'b1;
        step(20);
        check("mid_stays_idle", int'(wif.busy), 0);
        check("mid_q_empty", exp_q.size(), 0);

        // Same-direction re-request during the walk
        do_reset();
        e = ecnt + 1;
        wif.req_x = 1'b1;
        push_grant(1'b0, e + 1);
        step(1);
        wif.req_x = 1'b0;
        step(3);
        wif.req_x = 1'b1;
        push_grant(1'b0, e + 1 + PERIOD);
        step(1);
        wif.req_x = 1'b0;
        check("rereq_pend_x", int'(wif.pend_x), 1);
        step(6);
        check("rereq_pend_kept", int'(wif.pend_x), 1);
        check("rereq_clear", int'(wif.clear), 1);
        step(20);
        check("rereq_q_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
